// File: rtl/cdb_arbiter_if.sv
// Result-bus bundle between the functional units and the CDB arbiter.
// The arbiter takes the slave modport; the FU and ROB side takes the master modport.
interface cdb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [PREG_W-1:0] alu_pd;
  logic [DATA_W-1:0] alu_data;
  logic [ROB_W-1:0]  alu_rob;

  logic              b_valid;
  logic              b_ready;
  logic [PREG_W-1:0] b_pd;
  logic [DATA_W-1:0] b_data;
  logic [ROB_W-1:0]  b_rob;

  logic              mem_valid;
  logic              mem_ready;
  logic [PREG_W-1:0] mem_pd;
  logic [DATA_W-1:0] mem_data;
  logic [ROB_W-1:0]  mem_rob;

  logic [ROB_W-1:0]  rob_head;
  logic              mispredict;
  logic [ROB_W-1:0]  mispredict_tag;

  logic              cdb_valid;
  logic [PREG_W-1:0] cdb_pd;
  logic [DATA_W-1:0] cdb_data;
  logic [ROB_W-1:0]  cdb_rob;
  logic [1:0]        cdb_src;

  modport master (
    output alu_valid, alu_pd, alu_data, alu_rob,
    output b_valid, b_pd, b_data, b_rob,
    output mem_valid, mem_pd, mem_data, mem_rob,
    output rob_head, mispredict, mispredict_tag,
    input  alu_ready, b_ready, mem_ready,
    input  cdb_valid, cdb_pd, cdb_data, cdb_rob, cdb_src
  );

  modport slave (
    input  alu_valid, alu_pd, alu_data, alu_rob,
    input  b_valid, b_pd, b_data, b_rob,
    input  mem_valid, mem_pd, mem_data, mem_rob,
    input  rob_head, mispredict, mispredict_tag,
    output alu_ready, b_ready, mem_ready,
    output cdb_valid, cdb_pd, cdb_data, cdb_rob, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per FU, flush-aware, one broadcast per cycle.
// CDB_RR_EN selects round-robin; otherwise fixed priority B > MEM > ALU.
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 5
) (
  input logic         clk,
  input logic         reset,
  cdb_arbiter_if.slave bus
);
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_B   = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;

  logic [2:0]        in_v;
  logic [PREG_W-1:0] in_pd   [3];
  logic [DATA_W-1:0] in_data [3];
  logic [ROB_W-1:0]  in_rob  [3];

  logic [2:0]        slot_v;
  logic [PREG_W-1:0] slot_pd   [3];
  logic [DATA_W-1:0] slot_data [3];
  logic [ROB_W-1:0]  slot_rob  [3];

  logic [2:0] gnt;
  logic [1:0] gsel;
  logic [2:0] rdy;
  logic [2:0] hs;
  logic [2:0] flush;
  logic [2:0] drop;
  logic       kill;

  // Age is distance from the ROB head, so comparisons survive tag wrap.
  function automatic logic younger(
    input logic [ROB_W-1:0] t,
    input logic [ROB_W-1:0] m,
    input logic [ROB_W-1:0] h
  );
    logic [ROB_W-1:0] at;
    logic [ROB_W-1:0] am;
    at = t - h;
    am = m - h;
    return at > am;
  endfunction

  always_comb begin
    in_v       = {bus.mem_valid, bus.b_valid, bus.alu_valid};
    in_pd[0]   = bus.alu_pd;
    in_pd[1]   = bus.b_pd;
    in_pd[2]   = bus.mem_pd;
    in_data[0] = bus.alu_data;
    in_data[1] = bus.b_data;
    in_data[2] = bus.mem_data;
    in_rob[0]  = bus.alu_rob;
    in_rob[1]  = bus.b_rob;
    in_rob[2]  = bus.mem_rob;
  end

`ifdef CDB_RR_EN
  logic [1:0] last;

  always_comb begin
    gnt = '0;
    case (last)
      SRC_ALU: begin
        if (slot_v[1])      gnt = 3'b010;
        else if (slot_v[2]) gnt = 3'b100;
        else if (slot_v[0]) gnt = 3'b001;
      end
      SRC_B: begin
        if (slot_v[2])      gnt = 3'b100;
        else if (slot_v[0]) gnt = 3'b001;
        else if (slot_v[1]) gnt = 3'b010;
      end
      default: begin
        if (slot_v[0])      gnt = 3'b001;
        else if (slot_v[1]) gnt = 3'b010;
        else if (slot_v[2]) gnt = 3'b100;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      last <= SRC_MEM;
    else if (|gnt && !kill)
      last <= gsel;
  end
`else
  always_comb begin
    gnt = '0;
    if (slot_v[1])      gnt = 3'b010;
    else if (slot_v[2]) gnt = 3'b100;
    else if (slot_v[0]) gnt = 3'b001;
  end
`endif

  always_comb begin
    gsel = SRC_ALU;
    unique case (1'b1)
      gnt[0]:  gsel = SRC_ALU;
      gnt[1]:  gsel = SRC_B;
      gnt[2]:  gsel = SRC_MEM;
      default: gsel = SRC_ALU;
    endcase
  end

  always_comb begin
    rdy = ~slot_v | gnt;
    hs  = in_v & rdy;
    for (int i = 0; i < 3; i++) begin
      flush[i] = bus.mispredict &&
        younger(slot_rob[i], bus.mispredict_tag, bus.rob_head);
      drop[i]  = bus.mispredict &&
        younger(in_rob[i], bus.mispredict_tag, bus.rob_head);
    end
    kill = |gnt && flush[gsel];
  end

  assign bus.alu_ready = rdy[0];
  assign bus.b_ready   = rdy[1];
  assign bus.mem_ready = rdy[2];

  assign bus.cdb_valid = |gnt && !kill;
  assign bus.cdb_pd    = |gnt ? slot_pd[gsel]   : '0;
  assign bus.cdb_data  = |gnt ? slot_data[gsel] : '0;
  assign bus.cdb_rob   = |gnt ? slot_rob[gsel]  : '0;
  assign bus.cdb_src   = gsel;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_v <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (hs[i] && !drop[i]) begin
          slot_v[i]    <= 1'b1;
          slot_pd[i]   <= in_pd[i];
          slot_data[i] <= in_data[i];
          slot_rob[i]  <= in_rob[i];
        end else if (gnt[i] || flush[i]) begin
          slot_v[i]    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; expectations adapt to the CDB_RR_EN build.
// Inputs are driven 1 unit after posedge, outputs sampled 1 unit later.
module tb_cdb_arbiter;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  cdb_arbiter_if #(.DATA_W(32), .PREG_W(7), .ROB_W(5)) bus ();

  cdb_arbiter #(.DATA_W(32), .PREG_W(7), .ROB_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid  = 1'b0;
    bus.b_valid    = 1'b0;
    bus.mem_valid  = 1'b0;
    bus.mispredict = 1'b0;
  endtask

  task automatic put(input int s,
                     input logic [6:0]  pd,
                     input logic [31:0] data,
                     input logic [4:0]  rob);
    case (s)
      0: begin
        bus.alu_valid = 1'b1; bus.alu_pd = pd;
        bus.alu_data = data; bus.alu_rob = rob;
      end
      1: begin
        bus.b_valid = 1'b1; bus.b_pd = pd;
        bus.b_data = data; bus.b_rob = rob;
      end
      default: begin
        bus.mem_valid = 1'b1; bus.mem_pd = pd;
        bus.mem_data = data; bus.mem_rob = rob;
      end
    endcase
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [2:0] rdys();
    return {bus.mem_ready, bus.b_ready, bus.alu_ready};
  endfunction

  logic [1:0]  ord  [3];
  logic [2:0]  rdyx [3];
  logic [4:0]  frob [2];

  initial begin
    n_chk = 0;
    n_pass = 0;
    bus.alu_pd = '0; bus.alu_data = '0; bus.alu_rob = '0;
    bus.b_pd = '0; bus.b_data = '0; bus.b_rob = '0;
    bus.mem_pd = '0; bus.mem_data = '0; bus.mem_rob = '0;
    bus.rob_head = '0;
    bus.mispredict_tag = '0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", bus.cdb_valid, 0);
    chk("rst_pd", bus.cdb_pd, 0);
    chk("rst_data", bus.cdb_data, 0);
    chk("rst_rob", bus.cdb_rob, 0);
    chk("rst_src", bus.cdb_src, 0);
    chk("rst_ready", rdys(), 3'b111);

    // single ALU result
    put(0, 7'd5, 32'hDEAD_BEEF, 5'd3);
    #1;
    chk("single_rdy0", bus.alu_ready, 1);
    chk("single_v0", bus.cdb_valid, 0);
    tick();
    idle();
    #1;
    chk("single_v1", bus.cdb_valid, 1);
    chk("single_pd", bus.cdb_pd, 5);
    chk("single_data", bus.cdb_data, 32'hDEAD_BEEF);
    chk("single_rob", bus.cdb_rob, 3);
    chk("single_src", bus.cdb_src, 0);
    chk("single_rdy1", bus.alu_ready, 1);
    tick();
    #1;
    chk("single_v2", bus.cdb_valid, 0);

    // three-way contention
`ifdef CDB_RR_EN
    ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2;
    rdyx[0] = 3'b001; rdyx[1] = 3'b011; rdyx[2] = 3'b111;
`else
    ord[0] = 2'd1; ord[1] = 2'd2; ord[2] = 2'd0;
    rdyx[0] = 3'b010; rdyx[1] = 3'b110; rdyx[2] = 3'b111;
`endif
    do_reset();
    for (int s = 0; s < 3; s++)
      put(s, 7'(10 + s), 32'(32'hA0 + s), 5'(s + 1));
    #1;
    chk("cont_rdy0", rdys(), 3'b111);
    tick();
    idle();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("cont_v%0d", k), bus.cdb_valid, 1);
      chk($sformatf("cont_src%0d", k), bus.cdb_src, ord[k]);
      chk($sformatf("cont_data%0d", k), bus.cdb_data,
          32'(32'hA0 + ord[k]));
      chk($sformatf("cont_rdy%0d", k), rdys(), rdyx[k]);
      tick();
      #1;
    end
    chk("cont_end", bus.cdb_valid, 0);

`ifndef CDB_RR_EN
    // B streaming starves ALU until it stops
    do_reset();
    put(0, 7'd1, 32'h55, 5'd1);
    put(1, 7'd2, 32'd100, 5'd2);
    tick();
    idle();
    for (int i = 1; i < 5; i++) begin
      put(1, 7'd2, 32'(100 + i), 5'd2);
      #1;
      chk($sformatf("bp_src%0d", i), bus.cdb_src, 1);
      chk($sformatf("bp_data%0d", i), bus.cdb_data, 32'(99 + i));
      chk($sformatf("bp_ardy%0d", i), bus.alu_ready, 0);
      tick();
      idle();
    end
    #1;
    chk("bp_last_src", bus.cdb_src, 1);
    chk("bp_last_data", bus.cdb_data, 104);
    chk("bp_last_ardy", bus.alu_ready, 0);
    tick();
    #1;
    chk("bp_alu_v", bus.cdb_valid, 1);
    chk("bp_alu_src", bus.cdb_src, 0);
    chk("bp_alu_data", bus.cdb_data, 32'h55);
    tick();
    #1;
    chk("bp_end", bus.cdb_valid, 0);
`endif

    // flush with wrapped head: rob 2 younger than tag 1, rob 31 older
`ifdef CDB_RR_EN
    frob[0] = 5'd31; frob[1] = 5'd1;
`else
    frob[0] = 5'd1; frob[1] = 5'd31;
`endif
    do_reset();
    bus.rob_head = 5'd30;
    put(0, 7'd1, 32'h31, 5'd31);
    put(1, 7'd2, 32'h01, 5'd1);
    put(2, 7'd3, 32'h02, 5'd2);
    tick();
    idle();
    bus.mispredict = 1'b1;
    bus.mispredict_tag = 5'd1;
    put(2, 7'd4, 32'h04, 5'd4);
    #1;
    chk("fl_mrdy", bus.mem_ready, 0);
    chk("fl_v0", bus.cdb_valid, 1);
    chk("fl_rob0", bus.cdb_rob, frob[0]);
    tick();
    idle();
    #1;
    chk("fl_v1", bus.cdb_valid, 1);
    chk("fl_rob1", bus.cdb_rob, frob[1]);
    tick();
    #1;
    chk("fl_end", bus.cdb_valid, 0);

    // granted younger slot is masked; incoming younger result is discarded
    do_reset();
    bus.rob_head = 5'd30;
    put(2, 7'd3, 32'h02, 5'd2);
    tick();
    idle();
    bus.mispredict = 1'b1;
    bus.mispredict_tag = 5'd1;
    put(2, 7'd4, 32'h44, 5'd4);
    #1;
    chk("mask_v", bus.cdb_valid, 0);
    chk("mask_mrdy", bus.mem_ready, 1);
    tick();
    idle();
    put(2, 7'd4, 32'h45, 5'd4);
    #1;
    chk("disc_v", bus.cdb_valid, 0);
    tick();
    idle();
    #1;
    chk("ctl_v", bus.cdb_valid, 1);
    chk("ctl_rob", bus.cdb_rob, 4);
    chk("ctl_data", bus.cdb_data, 32'h45);

    // reset with all slots full and a handshake offered
    do_reset();
    bus.rob_head = 5'd0;
    for (int s = 0; s < 3; s++)
      put(s, 7'(20 + s), 32'(32'hC0 + s), 5'(s + 1));
    tick();
    idle();
    reset = 1'b1;
    put(1, 7'd7, 32'h77, 5'd7);
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("mrst_v", bus.cdb_valid, 0);
    chk("mrst_rdy", rdys(), 3'b111);
    tick();
    #1;
    chk("mrst_v2", bus.cdb_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
